// File: rtl/pim_pkg.sv
// Constants shared by the PIM activation and result paths, so that both
// directions agree on word width, word count and state encoding.
package pim_pkg;

  localparam int PIM_WORD_W    = 32;
  localparam int PIM_RES_WORDS = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } pim_state_e;

endpackage

// File: rtl/pim_result_buffer.sv
// Captures one wide PIM result in a single cycle and serialises it as
// WORD_W-bit words, most-significant slice first, for the bus side to pop.
//
// state    | meaning
// ST_IDLE  | nothing held; o_data_valid=0
// ST_DRAIN | shadow holds a result; o_data shows word o_counter
module pim_result_buffer
  import pim_pkg::*;
#(
  parameter  int WORD_W    = PIM_WORD_W,
  parameter  int NUM_WORDS = PIM_RES_WORDS,
  localparam int RES_W     = WORD_W * NUM_WORDS
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              i_result_valid,
  input  logic [RES_W-1:0]  i_result,
  input  logic              i_rd_en,
  input  logic              i_clear,
  output logic [WORD_W-1:0] o_data,
  output logic              o_data_valid,
  output logic [7:0]        o_counter,
  output logic              o_done,
  output logic              o_overrun
);

  localparam logic [7:0] LAST_IDX = 8'(NUM_WORDS - 1);

  pim_state_e        r_state;
  logic [RES_W-1:0]  r_shadow;
  logic [WORD_W-1:0] r_data;
  logic              r_data_valid;
  logic [7:0]        r_counter;
  logic              r_done;
  logic              r_overrun;

  logic              w_last;
  logic [7:0]        w_next_idx;
  logic [WORD_W-1:0] w_next_word;
  logic [WORD_W-1:0] w_new_word0;

  assign w_last      = (r_counter == LAST_IDX);
  assign w_next_idx  = r_counter + 8'd1;
  assign w_new_word0 = i_result[RES_W-1 -: WORD_W];

  // Word k of the shadow lives at the k-th slice counted down from the MSB.
  always_comb begin
    w_next_word = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (w_next_idx == 8'(k)) begin
        w_next_word = r_shadow[RES_W-1-k*WORD_W -: WORD_W];
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state      <= ST_IDLE;
      r_shadow     <= '0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_counter    <= '0;
      r_done       <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (i_clear) begin
      // Abort wins over capture and pop; a coincident strobe is not an overrun.
      r_state      <= ST_IDLE;
      r_data_valid <= 1'b0;
      r_counter    <= '0;
      r_done       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_result_valid) begin
            r_shadow     <= i_result;
            r_data       <= w_new_word0;
            r_counter    <= '0;
            r_data_valid <= 1'b1;
            r_state      <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (i_rd_en && w_last) begin
            r_done    <= 1'b1;
            r_counter <= '0;
            if (i_result_valid) begin
              // Back-to-back: the slot frees this cycle, so the new result fits.
              r_shadow     <= i_result;
              r_data       <= w_new_word0;
              r_data_valid <= 1'b1;
              r_state      <= ST_DRAIN;
            end else begin
              r_data_valid <= 1'b0;
              r_state      <= ST_IDLE;
            end
          end else begin
            if (i_rd_en) begin
              r_counter <= w_next_idx;
              r_data    <= w_next_word;
            end
            if (i_result_valid) begin
              r_overrun <= 1'b1;
            end
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_data_valid <= 1'b0;
          r_counter    <= '0;
        end
      endcase
    end
  end

  assign o_data       = r_data;
  assign o_data_valid = r_data_valid;
  assign o_counter    = r_counter;
  assign o_done       = r_done;
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_pim_result_buffer.sv
// Scoreboard bench: the driver keeps a word-list model of the buffer and
// queues expected words; a negedge monitor pops and compares on each read.
module tb_pim_result_buffer;

  localparam int WW    = 32;
  localparam int NW    = 8;
  localparam int RES_W = WW * NW;

  typedef struct {
    logic [WW-1:0] w;
    logic [7:0]    idx;
  } exp_t;

  logic              CLK = 1'b0;
  logic              RSTN = 1'b0;
  logic              i_result_valid = 1'b0;
  logic [RES_W-1:0]  i_result = '0;
  logic              i_rd_en = 1'b0;
  logic              i_clear = 1'b0;
  logic [WW-1:0]     o_data;
  logic              o_data_valid;
  logic [7:0]        o_counter;
  logic              o_done;
  logic              o_overrun;

  pim_result_buffer dut (
    .CLK            (CLK),
    .RSTN           (RSTN),
    .i_result_valid (i_result_valid),
    .i_result       (i_result),
    .i_rd_en        (i_rd_en),
    .i_clear        (i_clear),
    .o_data         (o_data),
    .o_data_valid   (o_data_valid),
    .o_counter      (o_counter),
    .o_done         (o_done),
    .o_overrun      (o_overrun)
  );

  always #5 CLK = ~CLK;

  exp_t          q[$];
  int            remaining = 0;
  logic          exp_done = 1'b0;
  logic          exp_overrun = 1'b0;
  logic          mon_en = 1'b0;
  logic [WW-1:0] cur_w[NW];
  int            n_tests = 0;
  int            n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Effect of the inputs that were just clocked, expressed as a word list.
  task automatic model_apply(input logic c, input logic rv, input logic rd);
    exp_done = 1'b0;
    if (c) begin
      q.delete();
      remaining   = 0;
      exp_overrun = 1'b0;
    end else if (remaining == 0) begin
      if (rv) begin
        for (int k = 0; k < NW; k++) q.push_back('{w: cur_w[k], idx: 8'(k)});
        remaining = NW;
      end
    end else if (rd) begin
      remaining--;
      if (remaining == 0) begin
        exp_done = 1'b1;
        if (rv) begin
          for (int k = 0; k < NW; k++) q.push_back('{w: cur_w[k], idx: 8'(k)});
          remaining = NW;
        end
      end else if (rv) begin
        exp_overrun = 1'b1;
      end
    end else if (rv) begin
      exp_overrun = 1'b1;
    end
  endtask

  task automatic drive(input logic c, input logic rv, input logic rd);
    logic [RES_W-1:0] r;
    for (int k = 0; k < NW; k++) r[RES_W-1-k*WW -: WW] = cur_w[k];
    i_clear        = c;
    i_result_valid = rv;
    i_rd_en        = rd;
    i_result       = r;
    @(posedge CLK);
    #1;
    model_apply(c, rv, rd);
  endtask

  task automatic set_words(input logic [WW-1:0] base);
    for (int k = 0; k < NW; k++) cur_w[k] = base + WW'(k);
  endtask

  task automatic set_random_words();
    for (int k = 0; k < NW; k++) cur_w[k] = $urandom;
  endtask

  always @(negedge CLK) begin
    if (RSTN && mon_en) begin
      check("valid", {63'd0, o_data_valid}, {63'd0, (remaining != 0)});
      check("done", {63'd0, o_done}, {63'd0, exp_done});
      check("overrun", {63'd0, o_overrun}, {63'd0, exp_overrun});
      if (o_data_valid && q.size() != 0) begin
        check("data", {32'd0, o_data}, {32'd0, q[0].w});
        check("counter", {56'd0, o_counter}, {56'd0, q[0].idx});
        if (i_rd_en && !i_clear) void'(q.pop_front());
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_data"}, {32'd0, o_data}, 64'd0);
    check({tag, "_valid"}, {63'd0, o_data_valid}, 64'd0);
    check({tag, "_counter"}, {56'd0, o_counter}, 64'd0);
    check({tag, "_done"}, {63'd0, o_done}, 64'd0);
    check({tag, "_overrun"}, {63'd0, o_overrun}, 64'd0);
  endtask

  initial begin
    set_words(32'h0);
    repeat (3) @(posedge CLK);
    #1;
    check_all_zero("reset");
    #2 RSTN = 1'b1;
    mon_en = 1'b1;

    // Single drain, reader always ready.
    set_words(32'h0);
    drive(0, 1, 0);
    for (int i = 0; i < NW; i++) drive(0, 0, 1);
    drive(0, 0, 0);

    // Stalled reader: 1,0,0 pattern.
    set_words(32'hA0);
    drive(0, 1, 0);
    for (int i = 0; i < 3 * NW; i++) drive(0, 0, (i % 3) == 0);
    drive(0, 0, 0);

    // Overrun: strobe after three pops, then finish draining.
    set_words(32'h10);
    drive(0, 1, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 1);
    for (int k = 0; k < NW; k++) cur_w[k] = 32'hFF;
    drive(0, 1, 0);
    for (int i = 0; i < NW - 3; i++) drive(0, 0, 1);
    drive(0, 0, 0);
    drive(1, 0, 0);

    // Back-to-back: B strobes together with A's final pop.
    set_words(32'h100);
    drive(0, 1, 0);
    for (int i = 0; i < NW - 1; i++) drive(0, 0, 1);
    set_words(32'h200);
    drive(0, 1, 1);
    for (int i = 0; i < NW; i++) drive(0, 0, 1);
    drive(0, 0, 0);

    // Clear beats a coincident strobe and pop, after an overrun was raised.
    set_words(32'h300);
    drive(0, 1, 1);
    drive(0, 0, 1);
    drive(0, 1, 0);
    drive(1, 1, 1);
    drive(0, 0, 0);

    // Asynchronous reset between edges at o_counter=4.
    set_words(32'h400);
    drive(0, 1, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 1);
    check("pre_rst_counter", {56'd0, o_counter}, 64'd4);
    i_result_valid = 1'b0;
    i_rd_en        = 1'b0;
    i_clear        = 1'b0;
    #1 RSTN = 1'b0;
    #1;
    check_all_zero("async_rst");
    q.delete();
    remaining   = 0;
    exp_done    = 1'b0;
    exp_overrun = 1'b0;
    #1 RSTN = 1'b1;
    set_words(32'h500);
    drive(0, 1, 0);
    for (int i = 0; i < NW; i++) drive(0, 0, 1);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      logic rv, rd, c;
      rv = ($urandom_range(0, 99) < 15);
      rd = ($urandom_range(0, 99) < 60);
      c  = ($urandom_range(0, 99) < 2);
      if (rv) set_random_words();
      drive(c, rv, rd);
    end

    for (int i = 0; i < 4 * NW && remaining != 0; i++) drive(0, 0, 1);
    drive(0, 0, 0);
    check("final_drained", 64'(remaining), 64'd0);
    check("queue_empty", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pim_result_buffer.md
Name: pim_result_buffer

Overview:
- Egress counterpart of the PIM activation path. Captures one wide result vector from the PIM macro in a single cycle, then serialises it as 32-bit words for the bus-side peripheral logic to read.
- Sits between the PIM macro outputs and the pim_wrap register/bus interface.
- Word ordering matches the activation packing:
  - word index 0 is the most-significant slice.
  - word index NUM_WORDS-1 is the least-significant slice.

Parameters:
- WORD_W, 32, width of one bus word.
- NUM_WORDS, 8, words per result vector; legal range 2..255.
- RES_W, WORD_W*NUM_WORDS, derived localparam; width of the captured result. Not overridable.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RSTN  input  1  asynchronous active-low reset.
- i_result_valid  input  1  single-cycle strobe; i_result is valid this cycle.
- i_result  input  RES_W  result vector from the PIM macro.
- i_rd_en  input  1  consumer pops the current word when o_data_valid=1.
- i_clear  input  1  synchronous abort: drop held data and clear o_overrun.
- o_data  output  WORD_W  current word, registered.
- o_data_valid  output  1  o_data holds an unread word.
- o_counter  output  8  index of the word currently on o_data.
- o_done  output  1  one-cycle pulse after the last word is popped.
- o_overrun  output  1  sticky: a result arrived while draining and was dropped.

Behaviour:
- Reset (RSTN=0, asynchronous):
  - State=IDLE.
  - Shadow register=0.
  - o_data=0, o_data_valid=0, o_counter=0, o_done=0, o_overrun=0.
- States: IDLE (nothing held) and DRAIN (shadow holds a result; o_data_valid=1).
- Word k corresponds to shadow[RES_W-1-k*WORD_W -: WORD_W].
- IDLE with i_result_valid=1:
  - Shadow <= i_result.
  - o_data <= i_result word 0.
  - o_counter <= 0.
  - o_data_valid <= 1.
  - Go to DRAIN.
  - Latency: first word is visible one cycle after the strobe.
- IDLE with i_rd_en=1: ignored; no state change.
- DRAIN pop (i_rd_en=1) when o_counter < NUM_WORDS-1:
  - o_counter <= o_counter+1.
  - o_data <= word[o_counter+1].
  - Next word is visible the cycle after the pop, so a reader asserting i_rd_en every cycle gets one word per cycle.
- DRAIN pop when o_counter == NUM_WORDS-1:
  - o_done <= 1 for exactly one cycle.
  - o_data_valid <= 0.
  - o_counter <= 0.
  - Return to IDLE.
  - o_data keeps the last word; its value is don't-care when o_data_valid=0.
- Final pop in the same cycle as i_result_valid (back-to-back):
  - The new result is accepted.
  - o_done pulses.
  - o_data_valid stays 1.
  - o_data <= new word 0, o_counter <= 0.
  - Remain in DRAIN.
  - o_overrun is not set.
- i_result_valid in DRAIN without a final pop:
  - The new result is dropped.
  - Shadow and the current drain are unchanged.
  - o_overrun <= 1 (sticky).
- i_clear=1 has highest priority over capture and pop in the same cycle:
  - State <= IDLE.
  - o_data_valid <= 0, o_counter <= 0, o_overrun <= 0.
  - o_done is not pulsed.
  - A coincident i_result_valid is discarded and does not set o_overrun.
- o_done is 0 in every cycle other than the one after a final pop.
- RSTN asserted mid-drain: immediate return to reset values; a partially read result is lost.
- No arithmetic is performed; widths are exact and there is no truncation. o_counter never exceeds NUM_WORDS-1.

Decomposition:
- Shared package pim_pkg:
  - PIM_WORD_W=32.
  - PIM_RES_WORDS=8.
  - State encoding constants: ST_IDLE=1'b0, ST_DRAIN=1'b1.
  - The same word-width constant is used by the activation-side logic so both directions agree on packing.
- Single module. Word selection is a NUM_WORDS-way mux on the shadow register, written inline; no sub-module is warranted.

Test Plan:
- Single drain:
  - Stimulus: reset, then i_result_valid with i_result = words 0x00000000..0x00000007 (word0 in the MSBs); i_rd_en held high.
  - Required: o_data reads 0,1,...,7 on 8 consecutive cycles with o_counter 0..7; o_done pulses once on the cycle after o_counter=7 is popped; o_data_valid then 0.
- Stalled reader:
  - Stimulus: capture 0xA0..0xA7; toggle i_rd_en 1,0,0,1,...
  - Required: o_data holds its value while i_rd_en=0; all 8 words arrive in order; no duplicates or skips.
- Overrun:
  - Stimulus: capture 0x10..0x17; pop 3 words; strobe i_result_valid with 0xFF..; drain the rest.
  - Required: o_overrun=1 from the next cycle; remaining words are 0x13..0x17; the 0xFF data never appears.
- Back-to-back:
  - Stimulus: capture result A; assert the second strobe (result B) in the same cycle as the final pop of A.
  - Required: o_done=1; o_data_valid stays 1; o_data=B word0 next cycle; o_overrun stays 0.
- Clear priority:
  - Stimulus: mid-drain, assert i_clear together with i_result_valid and i_rd_en.
  - Required: next cycle o_data_valid=0, o_counter=0, o_overrun=0, o_done=0; state IDLE.
- Async reset:
  - Stimulus: drop RSTN between clock edges at o_counter=4.
  - Required: all outputs go to 0 immediately, without a clock edge; a new capture after release starts at word 0.
